// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl
//   FF46 OAM DMA sequencer. A CPU write to FF46 latches a source page. After a
//   short start delay the block owns the external bus and copies XFER_LEN bytes
//   from {page,00..} into OAM 00..XFER_LEN-1, one byte per MCYCLE clocks.
//   Writing FF46 while busy restarts the copy from the new page. All outputs
//   are registered and are computed from the next-state values.
module oam_dma_ctrl #(
  parameter int unsigned XFER_LEN    = 160,
  parameter int unsigned MCYCLE      = 4,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ff46_sel,
  input  logic        i_cpu_wr,
  input  logic [7:0]  i_d_in,
  output logic [7:0]  o_d_out,
  output logic        o_busy,
  output logic        o_bus_req,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_rd,
  input  logic [7:0]  i_rd_data,
  output logic [7:0]  o_oam_addr,
  output logic [7:0]  o_oam_wdata,
  output logic        o_oam_we,
  output logic        o_oam_lock
);

  localparam int unsigned START_CLKS = START_DELAY * MCYCLE;
  localparam int unsigned PW         = $clog2(MCYCLE);
  localparam int unsigned CW         = (START_CLKS > 1) ? $clog2(START_CLKS) : 1;

  localparam logic [PW-1:0] PH_ZERO    = {PW{1'b0}};
  localparam logic [PW-1:0] PH_RD_LAST = PW'(MCYCLE - 2);
  localparam logic [PW-1:0] PH_WR      = PW'(MCYCLE - 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_LAST   = CW'(START_CLKS - 1);
  localparam logic [7:0]    IDX_LAST   = 8'(XFER_LEN - 1);
  localparam logic          NO_START   = (START_CLKS == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  // Echo RAM pages E0..FF alias C0..DF on the external bus.
  function automatic logic [7:0] f_echo_map(input logic [7:0] page);
    logic [7:0] mapped;
    if (page >= 8'hE0) begin
      mapped = page - 8'h20;
    end else begin
      mapped = page;
    end
    return mapped;
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_nxt;
  logic [7:0]    r_idx;
  logic [7:0]    w_idx_nxt;
  logic          r_pend;
  logic          w_pend_nxt;
  logic          r_hold;
  logic          w_hold_nxt;
  logic [7:0]    r_act_src;
  logic [7:0]    w_act_src_nxt;
  logic [7:0]    r_src;

  logic          w_wr_ev;
  logic          w_busy_nxt;
  logic          w_bus_req_nxt;
  logic          w_rd_nxt;
  logic          w_we_nxt;
  logic [15:0]   w_dma_addr_nxt;
  logic [7:0]    w_oam_addr_nxt;

  assign w_wr_ev = i_ff46_sel & i_cpu_wr;

  // Next-state, sequencing counters and next-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_phase_nxt   = r_phase;
    w_idx_nxt     = r_idx;
    w_pend_nxt    = r_pend;
    w_hold_nxt    = r_hold;
    w_act_src_nxt = r_act_src;

    case (r_state)
      ST_IDLE: begin
        w_hold_nxt = 1'b0;
        if (w_wr_ev) begin
          if (NO_START) begin
            w_state_nxt   = ST_XFER;
            w_phase_nxt   = PH_ZERO;
            w_idx_nxt     = 8'h00;
            w_act_src_nxt = f_echo_map(i_d_in);
          end else begin
            w_state_nxt = ST_START;
            w_cnt_nxt   = CNT_ZERO;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_wr_ev) begin
          // A new page during the delay restarts the delay.
          w_cnt_nxt = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = ST_XFER;
          w_phase_nxt   = PH_ZERO;
          w_idx_nxt     = 8'h00;
          w_act_src_nxt = f_echo_map(r_src);
          w_hold_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_XFER: begin
        if (r_phase == PH_WR) begin
          // Byte boundary: the OAM write of this byte completes on this edge.
          w_phase_nxt = PH_ZERO;
          if (r_pend || w_wr_ev) begin
            w_pend_nxt = 1'b0;
            w_idx_nxt  = 8'h00;
            if (NO_START) begin
              w_act_src_nxt = f_echo_map(w_wr_ev ? i_d_in : r_src);
            end else begin
              w_state_nxt = ST_START;
              w_cnt_nxt   = CNT_ZERO;
              w_hold_nxt  = 1'b1;
            end
          end else if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 8'h00;
          end else begin
            w_idx_nxt = r_idx + 8'h01;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
          w_pend_nxt  = r_pend | w_wr_ev;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_phase_nxt = PH_ZERO;
        w_idx_nxt   = 8'h00;
        w_pend_nxt  = 1'b0;
        w_hold_nxt  = 1'b0;
      end
    endcase

    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_bus_req_nxt = (w_state_nxt == ST_XFER) || ((w_state_nxt == ST_START) && w_hold_nxt);
    w_rd_nxt      = (w_state_nxt == ST_XFER) && (w_phase_nxt != PH_WR);
    w_we_nxt      = (w_state_nxt == ST_XFER) && (w_phase_nxt == PH_WR);

    if (w_rd_nxt) begin
      w_dma_addr_nxt = {w_act_src_nxt, w_idx_nxt};
    end else begin
      w_dma_addr_nxt = 16'h0000;
    end

    if (w_we_nxt) begin
      w_oam_addr_nxt = w_idx_nxt;
    end else begin
      w_oam_addr_nxt = 8'h00;
    end
  end

  // FSM state and sequencing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= CNT_ZERO;
      r_phase   <= PH_ZERO;
      r_idx     <= 8'h00;
      r_pend    <= 1'b0;
      r_hold    <= 1'b0;
      r_act_src <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_idx     <= w_idx_nxt;
      r_pend    <= w_pend_nxt;
      r_hold    <= w_hold_nxt;
      r_act_src <= w_act_src_nxt;
    end
  end

  // FF46 register: every write latches the page, in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= 8'h00;
      o_d_out <= 8'h00;
    end else if (w_wr_ev) begin
      r_src   <= i_d_in;
      o_d_out <= i_d_in;
    end
  end

  // Registered bus, OAM and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy      <= 1'b0;
      o_oam_lock  <= 1'b0;
      o_bus_req   <= 1'b0;
      o_dma_rd    <= 1'b0;
      o_dma_addr  <= 16'h0000;
      o_oam_we    <= 1'b0;
      o_oam_addr  <= 8'h00;
      o_oam_wdata <= 8'h00;
    end else begin
      o_busy     <= w_busy_nxt;
      o_oam_lock <= w_busy_nxt;
      o_bus_req  <= w_bus_req_nxt;
      o_dma_rd   <= w_rd_nxt;
      o_dma_addr <= w_dma_addr_nxt;
      o_oam_we   <= w_we_nxt;
      o_oam_addr <= w_oam_addr_nxt;
      // Read data is captured at the end of the last read phase of a byte.
      if ((r_state == ST_XFER) && (r_phase == PH_RD_LAST)) begin
        o_oam_wdata <= i_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl
//   Directed and randomized checks of the FF46 OAM DMA sequencer. A monitor
//   logs every bus read and OAM write with its cycle number; the main sequence
//   compares the logs against the expected transfer timeline.
module tb_oam_dma_ctrl;

  localparam int MC   = 4;
  localparam int LEN  = 160;
  localparam int LOGN = 16384;

  logic        clk;
  logic        rst_n;
  logic        i_ff46_sel;
  logic        i_cpu_wr;
  logic [7:0]  i_d_in;
  logic [7:0]  o_d_out;
  logic        o_busy;
  logic        o_bus_req;
  logic [15:0] o_dma_addr;
  logic        o_dma_rd;
  logic [7:0]  i_rd_data;
  logic [7:0]  o_oam_addr;
  logic [7:0]  o_oam_wdata;
  logic        o_oam_we;
  logic        o_oam_lock;

  oam_dma_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ff46_sel  (i_ff46_sel),
    .i_cpu_wr    (i_cpu_wr),
    .i_d_in      (i_d_in),
    .o_d_out     (o_d_out),
    .o_busy      (o_busy),
    .o_bus_req   (o_bus_req),
    .o_dma_addr  (o_dma_addr),
    .o_dma_rd    (o_dma_rd),
    .i_rd_data   (i_rd_data),
    .o_oam_addr  (o_oam_addr),
    .o_oam_wdata (o_oam_wdata),
    .o_oam_we    (o_oam_we),
    .o_oam_lock  (o_oam_lock)
  );

  // External memory model: data = low address byte ^ 5A.
  assign i_rd_data = o_dma_addr[7:0] ^ 8'h5A;

  logic [44:0] w_outs;
  assign w_outs = {o_d_out, o_busy, o_bus_req, o_dma_addr, o_dma_rd,
                   o_oam_addr, o_oam_wdata, o_oam_we, o_oam_lock};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  // Cycle counter: number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  int         rd_n = 0;
  int         wr_n = 0;
  int         bsy_n = 0;
  int         viol_n = 0;
  int         rd_c [LOGN];
  logic [15:0] rd_a [LOGN];
  int         wr_c [LOGN];
  logic [7:0] wr_a [LOGN];
  logic [7:0] wr_d [LOGN];

  // Monitor: log reads/writes, count busy clocks and structural violations.
  always @(negedge clk) begin
    if (o_dma_rd === 1'b1 && rd_n < LOGN) begin
      rd_c[rd_n] <= cyc;
      rd_a[rd_n] <= o_dma_addr;
      rd_n       <= rd_n + 1;
    end
    if (o_oam_we === 1'b1 && wr_n < LOGN) begin
      wr_c[wr_n] <= cyc;
      wr_a[wr_n] <= o_oam_addr;
      wr_d[wr_n] <= o_oam_wdata;
      wr_n       <= wr_n + 1;
    end
    if (o_busy === 1'b1) bsy_n <= bsy_n + 1;
    if (((o_dma_rd === 1'b1 || o_oam_we === 1'b1) && o_bus_req !== 1'b1) ||
        (o_oam_lock !== o_busy) || (o_dma_rd === 1'b1 && o_oam_we === 1'b1))
      viol_n <= viol_n + 1;
  end

  int total = 0;
  int bad = 0;
  int rd_ptr = 0;
  int wr_ptr = 0;

  function automatic logic [7:0] eff_page(input logic [7:0] p);
    if (p >= 8'hE0) return p - 8'h20;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is sampled on the next rising edge.
  task automatic do_write(input logic [7:0] v);
    i_ff46_sel = 1'b1;
    i_cpu_wr   = 1'b1;
    i_d_in     = v;
    @(negedge clk);
    i_ff46_sel = 1'b0;
    i_cpu_wr   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (o_busy === 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {63'd0, o_busy}, 64'd0);
  endtask

  // One transfer segment: first read at cycle s, n bytes from page.
  task automatic check_seg(input int s, input logic [7:0] page, input int n);
    logic [7:0] ep;
    logic [7:0] ib;
    ep = eff_page(page);
    for (int i = 0; i < n; i++) begin
      ib = 8'(i);
      for (int j = 0; j < MC - 1; j++) begin
        if (rd_ptr < rd_n) begin
          chk("rd_cycle", 64'(rd_c[rd_ptr]), 64'(s + MC * i + j));
          chk("rd_addr", {48'd0, rd_a[rd_ptr]}, {48'd0, ep, ib});
          rd_ptr++;
        end
      end
      if (wr_ptr < wr_n) begin
        chk("wr_cycle", 64'(wr_c[wr_ptr]), 64'(s + MC * i + MC - 1));
        chk("wr_addr", {56'd0, wr_a[wr_ptr]}, {56'd0, ib});
        chk("wr_data", {56'd0, wr_d[wr_ptr]}, {56'd0, ib ^ 8'h5A});
        wr_ptr++;
      end
    end
  endtask

  task automatic full_test(input logic [7:0] page);
    int w1, r0, wr0, b0;
    rd_ptr = rd_n; wr_ptr = wr_n; r0 = rd_n; wr0 = wr_n; b0 = bsy_n;
    do_write(page);
    w1 = cyc;
    wait_idle(LEN * MC + 100);
    if (rd_n > r0) chk("first_rd_latency", 64'(rd_c[r0] - w1), 64'd4);
    check_seg(w1 + MC, page, LEN);
    chk("rd_count", 64'(rd_n - r0), 64'(3 * LEN));
    chk("wr_count", 64'(wr_n - wr0), 64'(LEN));
    chk("busy_clks", 64'(bsy_n - b0), 64'd644);
    chk("d_out", {56'd0, o_d_out}, {56'd0, page});
  endtask

  // Start page pa, then write pb during byte k so that it is sampled while
  // the pre-edge state is phase j of that byte.
  task automatic restart_test(input logic [7:0] pa, input logic [7:0] pb,
                              input int k, input int j);
    int w1, s, r, r0, wr0, b0;
    rd_ptr = rd_n; wr_ptr = wr_n; r0 = rd_n; wr0 = wr_n; b0 = bsy_n;
    do_write(pa);
    w1 = cyc;
    s  = w1 + MC;
    while (cyc < s + MC * k + j) @(negedge clk);
    do_write(pb);
    r = s + MC * k + MC;
    while (cyc < r) @(negedge clk);
    for (int t = 0; t < MC; t++) begin
      chk("restart_gap", {60'd0, o_busy, o_bus_req, o_dma_rd, o_oam_we}, 64'hC);
      @(negedge clk);
    end
    wait_idle(LEN * MC + 100);
    check_seg(s, pa, k + 1);
    check_seg(r + MC, pb, LEN);
    chk("rs_rd_count", 64'(rd_n - r0), 64'((MC - 1) * (k + 1 + LEN)));
    chk("rs_wr_count", 64'(wr_n - wr0), 64'(k + 1 + LEN));
    chk("rs_busy_clks", 64'(bsy_n - b0), 64'(r + MC + LEN * MC - w1));
    chk("rs_d_out", {56'd0, o_d_out}, {56'd0, pb});
  endtask

  // Main directed/randomized sequence.
  initial begin
    int w1, s, w0, b0, r0;
    rst_n      = 1'b0;
    i_ff46_sel = 1'b0;
    i_cpu_wr   = 1'b0;
    i_d_in     = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {19'd0, w_outs}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain transfers: C1, echo page E5, random page.
    full_test(8'hC1);
    full_test(8'hE5);
    full_test(8'($urandom_range(0, 255)));

    // Select without write strobe, and strobe without select.
    b0 = bsy_n; r0 = rd_n; w0 = o_d_out;
    i_ff46_sel = 1'b1; i_d_in = 8'h3C;
    @(negedge clk);
    i_ff46_sel = 1'b0; i_cpu_wr = 1'b1;
    @(negedge clk);
    i_cpu_wr = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_trig_busy", 64'(bsy_n - b0), 64'd0);
    chk("no_trig_rd", 64'(rd_n - r0), 64'd0);
    chk("no_trig_dout", {56'd0, o_d_out}, 64'(w0));

    // Restart at idx 50, then restarts coinciding with the final byte.
    restart_test(8'hC1, 8'h80, 50, 1);
    restart_test(8'h40, 8'h90, 159, 2);
    restart_test(8'h41, 8'h91, 159, 3);
    for (int n = 0; n < 3; n++) begin
      restart_test(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   int'($urandom_range(0, 159)), int'($urandom_range(0, 3)));
      repeat (int'($urandom_range(1, 5))) @(negedge clk);
    end

    // Asynchronous reset at idx 20, phase 1.
    w0 = wr_n;
    do_write(8'hC3);
    w1 = cyc;
    s  = w1 + MC;
    while (cyc < s + MC * 20 + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {19'd0, w_outs}, 64'd0);
    chk("writes_before_reset", 64'(wr_n - w0), 64'd20);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b0 = bsy_n; w0 = wr_n;
    repeat (40) @(negedge clk);
    chk("post_reset_busy", 64'(bsy_n - b0), 64'd0);
    chk("post_reset_writes", 64'(wr_n - w0), 64'd0);
    chk("post_reset_dout", {56'd0, o_d_out}, 64'd0);
    full_test(8'($urandom_range(0, 255)));

    chk("structural_violations", 64'(viol_n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
